// File: rtl/clock_24h_ctrl.sv
// Prescaler and button-driven set-time sequencer for the 24 h timekeeper.
// mode is the FSM state register itself, so checkers can bind to it directly.
module clock_24h_ctrl #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TIMEOUT_S = 10,
   parameter int REPEAT_HS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic       sec_tick,
   output logic       hs_tick,
   output logic       load_h,
   output logic       load_m,
   output logic [5:0] value,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int HALF     = CLK_HZ / 2;
   localparam int PW       = $clog2(HALF);
   localparam int TO_TICKS = 2 * TIMEOUT_S;
   localparam int TW       = $clog2(TO_TICKS + 1);
   localparam int RW       = $clog2(REPEAT_HS + 2);

   localparam logic [PW-1:0] P_LAST = PW'(HALF - 1);
   localparam logic [PW-1:0] P_PRE  = PW'(HALF - 2);
   localparam logic [TW-1:0] T_LAST = TW'(TO_TICKS - 1);
   localparam logic [RW-1:0] R_ARM  = RW'(REPEAT_HS);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_SET_H = 2'd1;
   localparam logic [1:0] ST_SET_M = 2'd2;

   logic [PW-1:0] pcnt;
   logic          phase;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [RW-1:0] rcnt, rcnt_n;
   logic          mode_prev, inc_prev;
   logic          mode_press, inc_press, hs_pre;
   logic [5:0]    hour_mod, min_mod, base, lim, base_inc;
   logic [1:0]    state_n;
   logic [5:0]    value_n;
   logic          load_h_n, load_m_n, blink_n, restart;

   // hs_pre is the cycle before hs_tick is visible; the FSM acts on it so
   // blink, timeout and repeat changes line up with the visible tick.
   assign hs_pre     = (pcnt == P_PRE);
   assign mode_press = btn_mode & ~mode_prev;
   assign inc_press  = btn_inc & ~inc_prev & ~mode_press;

   assign hour_mod = {1'b0, cur_hour} % 6'd24;
   assign min_mod  = cur_min % 6'd60;
   // During the load_h cycle value still shows the hour; edits apply to the minute.
   assign base     = load_h ? min_mod : value;
   assign lim      = (mode == ST_SET_H) ? 6'd23 : 6'd59;
   assign base_inc = (base >= lim) ? 6'd0 : base + 6'd1;

   always_comb begin
      state_n  = mode;
      value_n  = (mode == ST_RUN) ? 6'd0 : base;
      load_h_n = 1'b0;
      load_m_n = 1'b0;
      blink_n  = blink;
      tcnt_n   = tcnt;
      rcnt_n   = (btn_inc && mode != ST_RUN) ? rcnt : '0;
      restart  = 1'b0;
      case (mode)
         ST_RUN: begin
            if (mode_press) begin
               state_n = ST_SET_H;
               value_n = hour_mod;
               blink_n = 1'b1;
               tcnt_n  = '0;
               rcnt_n  = '0;
            end
         end
         ST_SET_H, ST_SET_M: begin
            if (mode_press) begin
               tcnt_n = '0;
               if (mode == ST_SET_H) begin
                  state_n  = ST_SET_M;
                  load_h_n = 1'b1;
               end else begin
                  state_n  = ST_RUN;
                  load_m_n = 1'b1;
                  blink_n  = 1'b0;
                  restart  = 1'b1;
               end
            end else if (inc_press) begin
               value_n = base_inc;
               tcnt_n  = '0;
            end else if (hs_pre) begin
               blink_n = ~blink;
               if (btn_inc && rcnt == R_ARM) begin
                  value_n = base_inc;
                  tcnt_n  = '0;
               end else begin
                  if (btn_inc) rcnt_n = rcnt + RW'(1);
                  if (tcnt == T_LAST) begin
                     state_n = ST_RUN;
                     value_n = 6'd0;
                     blink_n = 1'b0;
                     tcnt_n  = '0;
                  end else begin
                     tcnt_n = tcnt + TW'(1);
                  end
               end
            end
         end
         default: begin
            state_n = ST_RUN;
            value_n = 6'd0;
            blink_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt      <= '0;
         phase     <= 1'b0;
         tcnt      <= '0;
         rcnt      <= '0;
         mode_prev <= 1'b0;
         inc_prev  <= 1'b0;
         mode      <= ST_RUN;
         value     <= 6'd0;
         load_h    <= 1'b0;
         load_m    <= 1'b0;
         blink     <= 1'b0;
         hs_tick   <= 1'b0;
         sec_tick  <= 1'b0;
      end else begin
         mode_prev <= btn_mode;
         inc_prev  <= btn_inc;
         mode      <= state_n;
         value     <= value_n;
         load_h    <= load_h_n;
         load_m    <= load_m_n;
         blink     <= blink_n;
         tcnt      <= tcnt_n;
         rcnt      <= rcnt_n;
         // Parking pcnt on its last count makes the next cycle look like the
         // first cycle after reset, so the first second after setting is full.
         if (restart) begin
            pcnt     <= P_LAST;
            phase    <= 1'b0;
            hs_tick  <= 1'b0;
            sec_tick <= 1'b0;
         end else begin
            pcnt     <= (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
            hs_tick  <= hs_pre;
            sec_tick <= hs_pre & phase & (state_n == ST_RUN);
            if (hs_pre) phase <= ~phase;
         end
      end
   end

endmodule

// File: tb/tb_clock_24h_ctrl.sv
// Directed bench for clock_24h_ctrl with CLK_HZ=8 (hs_tick every 4 cycles).
module tb_clock_24h_ctrl;

   localparam int CLK_HZ    = 8;
   localparam int TIMEOUT_S = 3;
   localparam int REPEAT_HS = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [4:0] cur_hour = 5'd0;
   logic [5:0] cur_min = 6'd0;
   logic       sec_tick, hs_tick, load_h, load_m, blink;
   logic [5:0] value;
   logic [1:0] mode;

   int n_checks = 0;
   int n_errors = 0;
   int n_load_h = 0;
   int n_load_m = 0;
   int n_both   = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   clock_24h_ctrl #(
      .CLK_HZ   (CLK_HZ),
      .TIMEOUT_S(TIMEOUT_S),
      .REPEAT_HS(REPEAT_HS)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_mode(btn_mode),
      .btn_inc (btn_inc),
      .cur_hour(cur_hour),
      .cur_min (cur_min),
      .sec_tick(sec_tick),
      .hs_tick (hs_tick),
      .load_h  (load_h),
      .load_m  (load_m),
      .value   (value),
      .mode    (mode),
      .blink   (blink)
   );

   // Strobe monitor
   always @(negedge clk) begin
      if (load_h) n_load_h++;
      if (load_m) n_load_m++;
      if (load_h && load_m) n_both++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Inputs set now are sampled at the next edge; on return we are in the
   // cycle where the press result is visible and the buttons are low again.
   task automatic press(input logic m, input logic i);
      btn_mode = m;
      btn_inc  = i;
      step();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
   endtask

   initial begin
      int found, ticks, h0, m0;
      logic [5:0] e;

      // Prescaler from reset, all edit outputs idle
      do_reset();
      for (int c = 1; c <= 40; c++) begin
         check("run_hs_tick", hs_tick, (c % 4 == 0));
         check("run_sec_tick", sec_tick, (c % 8 == 0));
         check("run_idle_outs", {load_h, load_m, value, mode, blink}, 0);
         step();
      end

      // Hour edit with wrap 23 -> 0, then hand over to minutes
      cur_hour = 5'd22;
      cur_min  = 6'd58;
      h0 = n_load_h;
      press(1'b1, 1'b0);
      check("seth_mode", mode, 1);
      check("seth_value", value, 22);
      check("seth_blink", blink, 1);
      exp_q = {6'd23, 6'd0, 6'd1};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         step();
         press(1'b0, 1'b1);
         check("seth_inc", value, e);
      end
      step();
      press(1'b1, 1'b0);
      check("load_h_strobe", load_h, 1);
      check("load_h_value", value, 1);
      check("load_h_mode", mode, 2);
      step();
      check("load_h_one_cycle", load_h, 0);
      check("setm_capture", value, 58);
      check("load_h_count", n_load_h - h0, 1);

      // Minute edit with wrap 59 -> 0, then restart of the second
      step();
      press(1'b0, 1'b1);
      check("setm_inc59", value, 59);
      step();
      press(1'b0, 1'b1);
      check("setm_wrap", value, 0);
      step();
      press(1'b1, 1'b0);
      check("load_m_strobe", load_m, 1);
      check("load_m_value", value, 0);
      check("load_m_mode", mode, 0);
      check("load_m_no_h", load_h, 0);
      found = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (sec_tick) begin
            found = k;
            break;
         end
      end
      check("sec_after_set", found, CLK_HZ);
      check("run_value_zero", value, 0);

      // Simultaneous mode+inc: mode wins each time
      cur_hour = 5'd9;
      step();
      press(1'b1, 1'b1);
      check("simul_mode", mode, 1);
      check("simul_value", value, 9);
      step();
      press(1'b1, 1'b1);
      check("simul_load_h", load_h, 1);
      check("simul_no_load_m", load_m, 0);
      check("simul_hold_value", value, 9);
      step();
      press(1'b1, 1'b0);
      check("simul_exit", mode, 0);

      // Timeout from SET_H with no activity
      do_reset();
      cur_hour = 5'd5;
      h0 = n_load_h;
      m0 = n_load_m;
      step();
      press(1'b1, 1'b0);
      check("to_enter", mode, 1);
      check("to_value", value, 5);
      ticks = 0;
      for (int k = 0; k < 60 && ticks < 2 * TIMEOUT_S; k++) begin
         step();
         if (hs_tick) begin
            ticks++;
            if (ticks == 2 * TIMEOUT_S - 1) check("to_still_set", mode, 1);
            if (ticks == 2 * TIMEOUT_S) begin
               check("to_mode_run", mode, 0);
               check("to_value_zero", value, 0);
               check("to_blink_off", blink, 0);
            end
         end
      end
      check("to_tick_count", ticks, 2 * TIMEOUT_S);
      check("to_no_load_h", n_load_h - h0, 0);
      check("to_no_load_m", n_load_m - m0, 0);

      // Reset in the middle of a minute edit
      step();
      press(1'b1, 1'b0);
      step();
      press(1'b1, 1'b0);
      check("mid_setm", mode, 2);
      step();
      h0 = n_load_h;
      m0 = n_load_m;
      reset = 1'b1;
      step();
      check("mid_reset_outs", {sec_tick, hs_tick, load_h, load_m, value, mode, blink}, 0);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) step();
      check("mid_reset_mode", mode, 0);
      check("mid_reset_no_load_h", n_load_h - h0, 0);
      check("mid_reset_no_load_m", n_load_m - m0, 0);

      // Auto-repeat while btn_inc is held
      do_reset();
      cur_hour = 5'd20;
      step();
      press(1'b1, 1'b0);
      check("rep_enter", value, 20);
      found = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (hs_tick) begin
            found = 1;
            break;
         end
      end
      check("rep_sync", found, 1);
      btn_inc = 1'b1;
      step();
      check("rep_press", value, 21);
      exp_q = {6'd21, 6'd21, 6'd22, 6'd23, 6'd0, 6'd1};
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
         step();
         if (hs_tick) check("rep_value", value, exp_q.pop_front());
      end
      check("rep_all_ticks", exp_q.size(), 0);
      check("rep_no_timeout", mode, 1);
      btn_inc = 1'b0;
      step();

      check("strobe_overlap", n_both, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clock_24h_ctrl.md
Name: clock_24h_ctrl

Overview:
- Single-clock controller that sequences the 24 h wall-clock timekeeper.
- Prescales the system clock into a 1 Hz second tick and a 2 Hz half-second tick. The timekeeper uses these as clock enables.
- Runs a button-driven set-time state machine that edits hour and minute and issues one-cycle load strobes carrying the new value.
- Sits between the debounced front-panel buttons and the timekeeper/display path.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency. Must be even and >= 4.
- TIMEOUT_S, 10, seconds with no button activity in a set state before aborting to RUN without loading.
- REPEAT_HS, 2, half-second ticks that btn_inc must be held before auto-repeat starts.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_mode  in  1  debounced level, active high.
- btn_inc  in  1  debounced level, active high.
- cur_hour  in  5  current hour from the timekeeper, 0..23.
- cur_min  in  6  current minute from the timekeeper, 0..59.
- sec_tick  out  1  one-cycle pulse once per second. Only issued in RUN.
- hs_tick  out  1  one-cycle pulse every half second. Issued in all states.
- load_h  out  1  one-cycle strobe: timekeeper loads value[4:0] into hour and zeroes seconds.
- load_m  out  1  one-cycle strobe: timekeeper loads value into minute and zeroes seconds.
- value  out  6  edit value. Range 0..23 in SET_H, 0..59 in SET_M, 0 in RUN.
- mode  out  2  state code: 0 RUN, 1 SET_H, 2 SET_M.
- blink  out  1  display blank enable for the field being edited. Toggles on each hs_tick in set states, 0 in RUN.

Behaviour:
- Reset: takes effect only at a clock edge. Every output goes to 0, state goes to RUN, and the prescaler, phase bit, timeout counter, repeat counter and edge-detect registers clear. Reset has priority over every other event, including mid-edit; a pending edit is discarded with no load strobe.
- Prescaler:
  - pcnt counts 0..CLK_HZ/2-1 and wraps.
  - hs_tick=1 in the cycle where pcnt==CLK_HZ/2-1.
  - A phase bit toggles on each hs_tick. sec_tick=1 on an hs_tick with phase==1, and only when state==RUN.
  - After reset, the first hs_tick occurs at cycle CLK_HZ/2 and the first sec_tick at cycle CLK_HZ.
- Edge detect: registered copies of both buttons. A press is a rising edge (now=1, prev=0). Each press is consumed in the cycle it is detected.
- All outputs are registered. A press detected in cycle N changes state, value and the strobes at the clock edge ending cycle N, so they are visible in cycle N+1.
- FSM transitions:
  - RUN + mode press -> SET_H. value <= cur_hour. blink <= 1. Timeout counter clears.
  - SET_H + inc press -> value <= (value==23) ? 0 : value+1.
  - SET_H + mode press -> SET_M. load_h pulses with value holding the hour for that cycle. value <= cur_min in the following cycle.
  - SET_M + inc press -> value <= (value==59) ? 0 : value+1.
  - SET_M + mode press -> RUN. load_m pulses with value holding the minute for that cycle.
  - Leaving SET_M also clears pcnt and the phase bit, so the first second after setting is a full CLK_HZ cycles.
  - SET_H/SET_M with no press for TIMEOUT_S*2 hs_ticks -> RUN with no load strobe.
  - Any press clears the timeout counter.
- Simultaneous mode and inc presses in the same cycle: mode wins and inc is ignored.
- inc press in RUN: ignored.
- Auto-repeat: while btn_inc is held in a set state, a repeat counter counts hs_ticks. Once it reaches REPEAT_HS, each further hs_tick increments value with the same wrap rule and clears the timeout. Releasing btn_inc clears the repeat counter.
- Wrap: increment never leaves the range for the current state. An out-of-range cur_hour/cur_min captured on entry is reduced with %24 or %60.
- load_h and load_m are never high together, and never high for more than one cycle.

Test Plan:
- CLK_HZ=8, reset for 2 cycles, then run 40 cycles -> hs_tick at cycles 4,8,12,…; sec_tick at cycles 8,16,24,32,40; all other outputs 0.
- cur_hour=22. Press mode, then 3 inc presses, then mode -> value goes 22,23,0,1; load_h pulses once with value=1; mode=2; value=cur_min next cycle.
- In SET_M with cur_min=58: 2 inc presses, then mode -> load_m with value=0; mode=0; next sec_tick exactly CLK_HZ cycles after the strobe.
- btn_mode and btn_inc rising in the same cycle from RUN -> mode=1, value=cur_hour with no increment; second simultaneous press in SET_H -> load_h with value unchanged.
- Enter SET_H, no presses for 2*TIMEOUT_S hs_ticks -> mode=0, no load_h/load_m ever asserted; assert reset mid-SET_M instead -> all outputs 0 next cycle, no strobe.
- Hold btn_inc in SET_H from value=20 for 6 hs_ticks with REPEAT_HS=2 -> value 21 (press), then 22,23,0,1 on hs_ticks 3..6; timeout does not fire.
